clock_divider_prog: RTL

Programmable successor to the fixed serial-bus clock divider: derives a glitch-free `slow_clk` from `sys_clk` with a runtime-loadable period, gated start/stop, and single-cycle phase strobes (rise, fall, mid-high, mid-low). It sits between `sys_clk` and the I2C/SPI masters. Those masters use the strobes as clock enables for driving and sampling, so nothing else in the design is clocked by `slow_clk`.

---
 rtl/clock_divider_prog_if.sv | 9 +
 rtl/clock_divider_prog.sv | 73 +++++++
 2 files changed

// File: rtl/clock_divider_prog_if.sv
// clock_divider_prog_if: period-configuration handshake between a controller and the divider
interface clock_divider_prog_if #(parameter int W = 16);
    logic [W-1:0] period;
    logic valid;
    logic ready;
    logic err;
    modport master(output period, valid, input ready, err);
    modport slave(input period, valid, output ready, err);
endinterface

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: programmable sys_clk divider with gated start/stop and phase strobes
module clock_divider_prog #(
    parameter int COUNTER_WIDTH = 16,
    parameter int DEFAULT_PERIOD = 125
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic enable,
    clock_divider_prog_if.slave cfg,
    output logic [COUNTER_WIDTH-1:0] active_period,
    output logic slow_clk,
    output logic rise_stb,
    output logic fall_stb,
    output logic mid_high_stb,
    output logic mid_low_stb,
    output logic busy
);
    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] TWO = COUNTER_WIDTH'(2);
    localparam logic [COUNTER_WIDTH-1:0] DEF = COUNTER_WIDTH'(DEFAULT_PERIOD);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t state, state_n;
    logic [COUNTER_WIDTH-1:0] cnt, cnt_n, pend_period, per_n, hi, lo, hi_n, lo_n;
    logic pend_valid, err_q, xfer, good, boundary, apply;
    assign cfg.ready = sys_rst_n & ~pend_valid;
    assign cfg.err = err_q;
    always_comb begin
        hi = active_period >> 1;
        lo = active_period - hi;
        xfer = cfg.valid & cfg.ready;
        good = cfg.period >= TWO;
        boundary = (state == HIGH) ? cnt == hi - ONE : cnt == lo - ONE;
        state_n = state == IDLE ? (enable ? HIGH : IDLE)
                : !boundary ? state
                : state == HIGH ? LOW
                : enable ? HIGH : IDLE;
        cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + ONE;
        // pending period lands only at the start of a high phase (or while idle) so no period is split
        apply = pend_valid & (state == IDLE || (state == LOW && state_n == HIGH));
        per_n = apply ? pend_period : active_period;
        hi_n = per_n >> 1;
        lo_n = per_n - hi_n;
    end
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            active_period <= DEF;
            pend_valid <= 1'b0;
            pend_period <= '0;
            err_q <= 1'b0;
            slow_clk <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            mid_high_stb <= 1'b0;
            mid_low_stb <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            active_period <= per_n;
            pend_valid <= apply ? 1'b0 : (xfer & good) | pend_valid;
            if (xfer & good) pend_period <= cfg.period;
            err_q <= xfer & ~good;
            slow_clk <= state_n == HIGH;
            rise_stb <= state_n == HIGH && state != HIGH;
            fall_stb <= state_n == LOW && state == HIGH;
            mid_high_stb <= state_n == HIGH && cnt_n == (hi_n >> 1);
            mid_low_stb <= state_n == LOW && cnt_n == (lo_n >> 1);
            busy <= state_n != IDLE;
        end
    end
endmodule
